// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control inputs and status outputs of the PC sequencer
interface pc_sequencer_if #(parameter int XLEN = 64);
    logic            PC_write;
    logic            PCSrc;
    logic [XLEN-1:0] pc_branch;
    logic            trap_req;
    logic [XLEN-1:0] trap_vec;
    logic [XLEN-1:0] pc_out;
    logic            pc_valid;
    logic            redirect;
    logic            done;
    logic            err;
    logic [XLEN-1:0] err_addr;
    logic [31:0]     fetch_cnt;
    logic [31:0]     stall_cnt;
    modport master (
        output PC_write, PCSrc, pc_branch, trap_req, trap_vec,
        input  pc_out, pc_valid, redirect, done, err, err_addr, fetch_cnt, stall_cnt
    );
    modport slave (
        input  PC_write, PCSrc, pc_branch, trap_req, trap_vec,
        output pc_out, pc_valid, redirect, done, err, err_addr, fetch_cnt, stall_cnt
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC generator with stall, pending redirect, trap, end and error handling
module pc_sequencer #(
    parameter int              XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] PC_LIMIT     = 'h200,
    parameter logic [XLEN-1:0] STEP         = 4,
    parameter int              ALIGN_BITS   = 2
) (
    input logic          clk,
    input logic          rst,
    pc_sequencer_if.slave bus
);
    typedef enum logic [1:0] {BOOT, RUN, DONE, ERR} state_t;
    localparam logic [XLEN-1:0] MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);
    localparam logic [XLEN-1:0] LAST = PC_LIMIT - STEP;
    state_t          state, state_n;
    logic            pend_v, pend_v_n;
    logic [XLEN-1:0] pend_a, pend_a_n;
    logic [XLEN-1:0] pc_n, err_addr_n, tgt;
    logic            err_n, redirect_n, fetch_inc, stall_inc, take;
    function automatic logic legal(input logic [XLEN-1:0] a);
        return ((a & MASK) == '0) && (a < PC_LIMIT);
    endfunction
    // next-state, next-PC and pending-redirect selection; trap beats branch beats sequential
    always_comb begin
        state_n    = state;
        pc_n       = bus.pc_out;
        pend_v_n   = pend_v;
        pend_a_n   = pend_a;
        err_n      = bus.err;
        err_addr_n = bus.err_addr;
        redirect_n = 1'b0;
        fetch_inc  = 1'b0;
        stall_inc  = 1'b0;
        take       = bus.trap_req || (bus.PC_write && (bus.PCSrc || pend_v));
        tgt        = bus.trap_req ? bus.trap_vec : (bus.PCSrc ? bus.pc_branch : pend_a);
        case (state)
            BOOT: state_n = RUN;
            RUN: begin
                if (take) begin
                    pend_v_n = 1'b0;
                    if (legal(tgt)) begin
                        pc_n       = tgt;
                        redirect_n = 1'b1;
                        fetch_inc  = 1'b1;
                    end else begin
                        err_n      = 1'b1;
                        err_addr_n = tgt;
                        state_n    = ERR;
                    end
                end else if (bus.PC_write) begin
                    if (bus.pc_out >= LAST) state_n = DONE;
                    else begin
                        pc_n      = bus.pc_out + STEP;
                        fetch_inc = 1'b1;
                    end
                end else begin
                    stall_inc = 1'b1;
                    if (bus.PCSrc) begin
                        pend_v_n = 1'b1;
                        pend_a_n = bus.pc_branch;
                    end
                end
            end
            ERR: begin
                if (bus.trap_req && legal(bus.trap_vec)) begin
                    pc_n       = bus.trap_vec;
                    redirect_n = 1'b1;
                    err_n      = 1'b0;
                    state_n    = RUN;
                end else if (bus.trap_req) err_addr_n = bus.trap_vec;
            end
            default: ;
        endcase
    end
    // state and registered outputs; counters saturate at all-ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= BOOT;
            pend_v        <= 1'b0;
            pend_a        <= '0;
            bus.pc_out    <= RESET_VECTOR;
            bus.pc_valid  <= 1'b0;
            bus.redirect  <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
            bus.err_addr  <= '0;
            bus.fetch_cnt <= '0;
            bus.stall_cnt <= '0;
        end else begin
            state         <= state_n;
            pend_v        <= pend_v_n;
            pend_a        <= pend_a_n;
            bus.pc_out    <= pc_n;
            bus.pc_valid  <= state_n == RUN;
            bus.redirect  <= redirect_n;
            bus.done      <= state_n == DONE;
            bus.err       <= err_n;
            bus.err_addr  <= err_addr_n;
            bus.fetch_cnt <= bus.fetch_cnt + 32'(fetch_inc && bus.fetch_cnt != '1);
            bus.stall_cnt <= bus.stall_cnt + 32'(stall_inc && bus.stall_cnt != '1);
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scoreboard bench for pc_sequencer
module tb_pc_sequencer;
    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] val;
    } exp_t;
    localparam int PC = 0, VAL = 1, RED = 2, DN = 3, ER = 4, EA = 5, FC = 6, SC = 7;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    pc_sequencer_if #(.XLEN(64)) bus ();
    pc_sequencer dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    function automatic logic [63:0] obs(input int sel);
        case (sel)
            PC:      return bus.pc_out;
            VAL:     return 64'(bus.pc_valid);
            RED:     return 64'(bus.redirect);
            DN:      return 64'(bus.done);
            ER:      return 64'(bus.err);
            EA:      return bus.err_addr;
            FC:      return 64'(bus.fetch_cnt);
            default: return 64'(bus.stall_cnt);
        endcase
    endfunction
    task automatic e(input string tag, input int sel, input logic [63:0] val);
        sb.push_back('{tag, sel, val});
    endtask
    task automatic check_all();
        exp_t        x;
        logic [63:0] o;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            o = obs(x.sel);
            tests++;
            assert (o === x.val) else begin
                fails++;
                $error("FAIL %s: observed %0h expected %0h", x.tag, o, x.val);
            end
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
        check_all();
    endtask
    task automatic drive(input logic w, input logic src, input logic [63:0] br, input logic tr, input logic [63:0] tv);
        bus.PC_write  = w;
        bus.PCSrc     = src;
        bus.pc_branch = br;
        bus.trap_req  = tr;
        bus.trap_vec  = tv;
    endtask
    task automatic reset_pulse();
        #2 rst = 1'b0;
        #1;
        e("rst_pc", PC, 0); e("rst_valid", VAL, 0); e("rst_red", RED, 0); e("rst_done", DN, 0);
        e("rst_err", ER, 0); e("rst_ea", EA, 0); e("rst_fc", FC, 0); e("rst_sc", SC, 0);
        check_all();
        #1 rst = 1'b1;
        #1;
        e("boot_pc", PC, 0); e("boot_valid", VAL, 0);
        check_all();
        tick();
    endtask
    initial begin
        drive(1, 0, 0, 0, 0);
        #3;
        e("por_pc", PC, 0); e("por_valid", VAL, 0); e("por_done", DN, 0); e("por_err", ER, 0);
        check_all();
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        e("boot_pc", PC, 0); e("boot_valid", VAL, 0);
        check_all();
        e("run_pc0", PC, 0); e("run_valid", VAL, 1); e("run_fc0", FC, 0);
        tick();
        for (int i = 1; i <= 127; i++) begin
            e("seq_pc", PC, 64'(4 * i));
            tick();
        end
        e("last_fc", FC, 127); e("last_done", DN, 0); e("last_valid", VAL, 1);
        check_all();
        e("end_pc", PC, 'h1FC); e("end_done", DN, 1); e("end_valid", VAL, 0); e("end_fc", FC, 127);
        tick();
        drive(1, 1, 'h40, 1, 'h100);
        e("dn_pc", PC, 'h1FC); e("dn_done", DN, 1); e("dn_red", RED, 0);
        tick();
        e("dn2_pc", PC, 'h1FC); e("dn2_done", DN, 1);
        tick();
        drive(1, 0, 0, 0, 0);
        reset_pulse();
        e("r2_pc", PC, 0);
        check_all();
        for (int i = 1; i <= 4; i++) begin
            e("r2_seq", PC, 64'(4 * i));
            tick();
        end
        drive(0, 1, 'h80, 0, 0);
        e("st1_pc", PC, 'h10); e("st1_sc", SC, 1);
        tick();
        drive(0, 1, 'h40, 0, 0);
        e("st2_pc", PC, 'h10); e("st2_sc", SC, 2);
        tick();
        drive(0, 0, 0, 0, 0);
        e("st3_pc", PC, 'h10); e("st3_sc", SC, 3); e("st3_red", RED, 0);
        tick();
        drive(1, 0, 0, 0, 0);
        e("pend_pc", PC, 'h40); e("pend_red", RED, 1); e("pend_fc", FC, 5);
        tick();
        e("pend2_pc", PC, 'h44); e("pend2_red", RED, 0); e("pend2_fc", FC, 6);
        tick();
        drive(0, 1, 'h40, 1, 'h180);
        e("trap_pc", PC, 'h180); e("trap_red", RED, 1); e("trap_sc", SC, 3); e("trap_fc", FC, 7);
        tick();
        drive(1, 0, 0, 0, 0);
        e("post_trap_pc", PC, 'h184); e("post_trap_fc", FC, 8);
        tick();
        drive(1, 1, 'h22, 0, 0);
        e("mis_err", ER, 1); e("mis_ea", EA, 'h22); e("mis_valid", VAL, 0); e("mis_pc", PC, 'h184); e("mis_fc", FC, 8);
        tick();
        drive(1, 0, 0, 0, 0);
        e("err_hold_pc", PC, 'h184); e("err_hold_err", ER, 1);
        tick();
        drive(1, 0, 0, 1, 'h102);
        e("bad_trap_err", ER, 1); e("bad_trap_ea", EA, 'h102); e("bad_trap_pc", PC, 'h184);
        tick();
        drive(1, 0, 0, 1, 'h100);
        e("exit_pc", PC, 'h100); e("exit_err", ER, 0); e("exit_valid", VAL, 1); e("exit_red", RED, 1); e("exit_ea", EA, 'h102);
        tick();
        drive(1, 0, 0, 0, 0);
        e("exit2_pc", PC, 'h104);
        tick();
        drive(1, 1, 'h200, 0, 0);
        e("lim_err", ER, 1); e("lim_ea", EA, 'h200); e("lim_pc", PC, 'h104);
        tick();
        drive(1, 0, 0, 0, 0);
        reset_pulse();
        e("r3_pc", PC, 0); e("r3_err", ER, 0); e("r3_ea", EA, 0);
        check_all();
        e("r3_seq", PC, 4);
        tick();
        drive(0, 1, 'h80, 0, 0);
        e("r3_st_pc", PC, 4); e("r3_st_sc", SC, 1);
        tick();
        drive(1, 0, 0, 0, 0);
        reset_pulse();
        e("r4_pc", PC, 0); e("r4_valid", VAL, 1); e("r4_red", RED, 0);
        check_all();
        e("r4_nostale_pc", PC, 4); e("r4_nostale_red", RED, 0);
        tick();
        drive(1, 0, 0, 1, 'h7);
        e("itrap_err", ER, 1); e("itrap_ea", EA, 'h7); e("itrap_pc", PC, 4);
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The parameter XLEN SHALL default to 64 and set the PC and target width.
REQ-002 The parameter RESET_VECTOR SHALL default to 0 and give the boot PC.
REQ-003 The parameter PC_LIMIT SHALL default to 'h200 and give the exclusive upper PC bound (128 instructions x 4 B).
REQ-004 The parameter STEP SHALL default to 4 and give the sequential increment.
REQ-005 The parameter ALIGN_BITS SHALL default to 2 and give the number of low target bits that must be zero.
REQ-006 The port list SHALL be:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset; asynchronous, active-low (asserted at 0).
- PC_write  in  1  1 = advance allowed, 0 = stall.
- PCSrc  in  1  branch/jump redirect request.
- pc_branch  in  XLEN  redirect target.
- trap_req  in  1  trap redirect request, highest priority.
- trap_vec  in  XLEN  trap target.
- pc_out  out  XLEN  current fetch PC.
- pc_valid  out  1  pc_out is a valid fetch address.
- redirect  out  1  one-cycle pulse, pc_out was just loaded from a target.
- done  out  1  program end reached.
- err  out  1  illegal redirect target.
- err_addr  out  XLEN  offending target.
- fetch_cnt  out  32  PC updates in RUN, saturating.
- stall_cnt  out  32  stalled RUN cycles, saturating.

Function
REQ-007 The FSM SHALL have the states BOOT, RUN, DONE and ERR, held in registers.
REQ-008 BOOT SHALL last exactly one cycle after reset release, hold pc_out = RESET_VECTOR with pc_valid = 0, then enter RUN.
REQ-009 In RUN, pc_valid SHALL be 1; in BOOT, DONE and ERR it SHALL be 0.
REQ-010 A target SHALL be legal when its low ALIGN_BITS bits are 0 and it is < PC_LIMIT.
REQ-011 In RUN, the next-PC priority SHALL be, in order:
- trap_req
- pending redirect or PCSrc with PC_write = 1
- sequential pc_out + STEP with PC_write = 1
- hold
REQ-012 trap_req SHALL take effect regardless of PC_write and SHALL clear any pending redirect.
REQ-013 PCSrc asserted while PC_write = 0 SHALL latch pc_branch into a single pending register; a later PCSrc while still stalled SHALL overwrite it.
REQ-014 The pending redirect SHALL apply on the first cycle with PC_write = 1, and PCSrc in that same cycle SHALL win over the pending value.
REQ-015 A legal redirect SHALL load pc_out with the target and pulse redirect for one cycle.
REQ-016 An illegal redirect SHALL hold pc_out, capture the target in err_addr, set err, and enter ERR.
REQ-017 A sequential step with pc_out >= PC_LIMIT - STEP SHALL hold pc_out, set done, and enter DONE; pc_out SHALL never exceed PC_LIMIT - STEP.
REQ-018 The sequential add SHALL be XLEN-bit unsigned and SHALL never wrap, because the REQ-017 check precedes it.
REQ-019 DONE SHALL be terminal until reset; all requests in DONE SHALL be ignored.
REQ-020 In ERR, only a trap_req with a legal trap_vec SHALL exit:
- pc_out is loaded with trap_vec and the FSM enters RUN.
- err is cleared, redirect pulses, and err_addr is retained.
REQ-021 A trap_req with an illegal trap_vec (in RUN or ERR) SHALL be treated as an illegal redirect per REQ-016.
REQ-022 fetch_cnt SHALL increment on every pc_out update in RUN (sequential or redirect) and saturate at 'hFFFFFFFF.
REQ-023 stall_cnt SHALL increment on every RUN cycle with PC_write = 0 and no trap_req, and saturate at 'hFFFFFFFF.
REQ-024 All outputs SHALL be registered; the block SHALL contain no simulation-only constructs (no $finish, no $display).

Reset
REQ-025 rst = 0 SHALL immediately force the following, independent of clk and PC_write:
- pc_out = RESET_VECTOR, FSM = BOOT, pending cleared.
- pc_valid = redirect = done = err = 0.
- err_addr = fetch_cnt = stall_cnt = 0.
REQ-026 Reset asserted mid-stall or in DONE/ERR SHALL discard all state; after release the sequence SHALL restart at REQ-008.

Verification
REQ-027 Reset release, PC_write = 1 held -> BOOT for 1 cycle, then pc_out = 0, 4, 8, ... until pc_out = 'h1FC, then done = 1 on the next edge; fetch_cnt = 127, pc_out stays 'h1FC.
REQ-028 At pc_out = 'h10, PC_write = 0 for 3 cycles with PCSrc pulsed (pc_branch = 'h80) in cycle 1 and again (pc_branch = 'h40) in cycle 2, then PC_write = 1 -> pc_out holds 'h10, stall_cnt = 3, next pc_out = 'h40, redirect pulses once.
REQ-029 PCSrc = 1 with pc_branch = 'h22 -> err = 1, err_addr = 'h22, pc_valid = 0, pc_out unchanged; then trap_req with trap_vec = 'h100 -> RUN, pc_out = 'h100, err = 0.
REQ-030 trap_req (trap_vec = 'h180) and PCSrc (pc_branch = 'h40) in the same cycle with PC_write = 0 -> pc_out = 'h180, pending cleared, the following cycle is sequential 'h184.
REQ-031 pc_branch = 'h200 (= PC_LIMIT) -> ERR entered; in DONE, any trap_req and PCSrc -> no change in pc_out or done.
REQ-032 rst = 0 asserted between clock edges while stalled with a pending redirect -> outputs reset immediately; after release, no stale redirect is applied and pc_out = RESET_VECTOR.
